// File: rtl/or_lane_pkg.sv
// Shared types and constants for the OR lane scheduler.
package or_lane_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    // Wide enough for the largest supported datapath latency (7).
    localparam int unsigned CntW = 3;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/or_lane_scheduler_if.sv
// Requester, shared-datapath and response signals of the OR lane scheduler.
interface or_lane_scheduler_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 6,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      dp_a;
    logic [W-1:0]      dp_b;
    logic              dp_vld;
    logic [W-1:0]      dp_res;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;

    // Requesters plus the shared datapath, seen from outside the scheduler.
    modport master (
        output req, req_a, req_b, dp_res, rsp_rdy,
        input  gnt, dp_a, dp_b, dp_vld, rsp_vld, rsp_id, rsp_data
    );

    // The scheduler itself.
    modport slave (
        input  req, req_a, req_b, dp_res, rsp_rdy,
        output gnt, dp_a, dp_b, dp_vld, rsp_vld, rsp_id, rsp_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic [NREQ-1:0] req_rot;
    logic            found;
    int unsigned     off;
    int unsigned     pos;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        req_rot = '0;
        found   = 1'b0;
        off     = 0;
        pos     = 0;
        gnt     = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rot[i] = req[(i + int'(ptr)) % NREQ];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
        if (found) begin
            pos      = (off + int'(ptr)) % NREQ;
            gnt[pos] = 1'b1;
            idx      = IDW'(pos);
        end
    end

endmodule

// File: rtl/or_lane_scheduler.sv
// Round-robin scheduler sharing one fixed-latency OR lane datapath among NREQ requesters.
module or_lane_scheduler
    import or_lane_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 6,
    parameter int unsigned LAT  = 2,
    parameter int unsigned IDW  = clog2(NREQ)
) (
    input logic               clk,
    input logic               rst_n,
    or_lane_scheduler_if.slave bus
);
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [W-1:0]    dp_a_q, dp_b_q, rsp_data_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic [IDW-1:0]  ptr_nxt;
    logic            issue;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (bus.req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign issue   = (state_q == StIdle) && (|bus.req);
    assign ptr_nxt = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one grant per pass, latency count in EXEC, hold RESP until accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|bus.req) state_d = StExec;
            StExec:  if (cnt_q == CntW'(1)) state_d = StResp;
            StResp:  if (bus.rsp_rdy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand capture on grant, latency counter, result capture on the last EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            if (issue) begin
                dp_a_q   <= bus.req_a[int'(arb_idx)*W +: W];
                dp_b_q   <= bus.req_b[int'(arb_idx)*W +: W];
                rsp_id_q <= arb_idx;
                rr_ptr_q <= ptr_nxt;
                cnt_q    <= CntW'(LAT);
            end
            if (state_q == StExec) begin
                cnt_q <= cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    rsp_data_q <= bus.dp_res;
                end
            end
        end
    end

    // Outputs: grant only while idle, issue strobe on the first EXEC cycle (cnt still full).
    always_comb begin
        bus.gnt      = (state_q == StIdle) ? arb_gnt : '0;
        bus.dp_vld   = (state_q == StExec) && (cnt_q == CntW'(LAT));
        bus.rsp_vld  = (state_q == StResp);
        bus.dp_a     = dp_a_q;
        bus.dp_b     = dp_b_q;
        bus.rsp_id   = rsp_id_q;
        bus.rsp_data = rsp_data_q;
    end

endmodule

// File: doc/or_lane_scheduler.md
Name: or_lane_scheduler

Overview:
- Shares one fixed-latency W-bit lane datapath among NREQ requesters.
- The datapath is the per-bit "i1 ? i1 : i2" select cell (bitwise OR) plus its capture register, as used in the simple_and regression tops.
- The block arbitrates round-robin, issues one operation at a time, counts the datapath latency, captures the result, and returns it with the winner's ID over a ready/valid response port.
- It sits between requester logic and a single shared datapath instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 6, operand/result width. Matches the N2+1 lane width with N1=4.
- LAT, 2, datapath latency in cycles from dp_vld to a valid dp_res (1..7).
- IDW, 2, response ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- req_a  in  NREQ*W  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*W  packed operand B; slice i belongs to requester i.
- gnt  out  NREQ  one-hot grant pulse, one cycle; the operands of that requester are captured on this edge.
- dp_a  out  W  operand A to the shared datapath.
- dp_b  out  W  operand B to the shared datapath.
- dp_vld  out  1  issue strobe to the datapath.
- dp_res  in  W  datapath result.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_id  out  IDW  index of the granted requester.
- rsp_data  out  W  captured result.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; rr_ptr=0; gnt, dp_vld and rsp_vld are 0; dp_a, dp_b, rsp_id and rsp_data are 0.
- Clock and reset are fixed as one clock, clk, with asynchronous active-low reset rst_n.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If req is nonzero, gnt is driven combinationally to the first set bit, searching from rr_ptr upward with wrap.
  - At the clock edge: latch the winner's req_a and req_b into dp_a and dp_b, latch its index into rsp_id, set rr_ptr=(winner+1) mod NREQ, load cnt=LAT, and go to EXEC.
  - If req=0: gnt=0 and the block stays in IDLE.
- EXEC:
  - dp_vld=1 in the first EXEC cycle only.
  - dp_a and dp_b are held stable throughout EXEC.
  - cnt decrements once per cycle.
  - In the cycle with cnt==1, dp_res is sampled into rsp_data at the edge and the state goes to RESP.
- RESP:
  - rsp_vld=1, with rsp_data and rsp_id stable.
  - On rsp_vld&rsp_rdy, go to IDLE.
  - No grant is issued in the same cycle; the next grant comes at the earliest in the following IDLE cycle.
- Latency: request seen in IDLE at cycle t -> gnt at t -> dp_vld at t+1 -> rsp_vld from t+LAT+1.
- Peak throughput: one operation per LAT+2 cycles.
- Fairness: a requester that holds req high is granted within NREQ operations.
- A requester that drops req after its grant does not cancel the operation.
- A new req arriving during EXEC or RESP waits; it is not lost while req stays high.
- Simultaneous requests: round-robin order from rr_ptr. Example: rr_ptr=2, req=1011 grants requester 3 next, then 0, then 1.
- rsp_rdy held low: the block stays in RESP indefinitely with outputs stable; gnt stays 0.
- rsp_rdy high on rsp_vld entry: the block spends exactly one RESP cycle.
- rr_ptr wraps from NREQ-1 to 0.
- Reset asserted mid-EXEC or mid-RESP: the operation is aborted immediately and all outputs return to reset values. No response is produced for the aborted operation.
- gnt is never asserted outside IDLE and is always one-hot or zero.

Decomposition:
- Shared package or_lane_pkg holds:
  - the state enum (IDLE, EXEC, RESP);
  - the cnt width constant (3 bits, covering LAT max 7);
  - a clog2 function for IDW.
- One sub-module, rr_arbiter:
  - parameter NREQ; inputs req and ptr; outputs one-hot gnt and winner index;
  - purely combinational, with rotate / priority-find / unrotate.
- FSM, counter and operand/result registers live in or_lane_scheduler.

Test Plan (the datapath model is a registered bitwise OR with LAT=2):
1. Single request: req=0001, a0=6'h05, b0=6'h0A, rsp_rdy=1 -> gnt=0001 at cycle 0; dp_vld at cycle 1; rsp_vld at cycle 3 with rsp_id=0, rsp_data=6'h0F; back in IDLE at cycle 4.
2. All request from reset: req=1111 held, operands distinct per requester -> grants in order 0,1,2,3,0, spaced 4 cycles apart; each rsp_data is the OR of the matching requester's operands.
3. Backpressure: requester 1 only, rsp_rdy=0 for 10 cycles, then 1 -> rsp_vld held 10+ cycles with rsp_id=1 and data stable; gnt=0 throughout; IDLE the cycle after the handshake.
4. Mid-operation request: requester 0 granted, requester 2 raises req during EXEC -> requester 2 granted in the first IDLE cycle after the requester-0 response handshake.
5. Reset during EXEC: rst_n low in cycle 2 of op 1 -> dp_vld, rsp_vld and gnt are 0 immediately; no response; rr_ptr=0; after release, req=0100 is granted normally.
6. Wrap and latency sweep: rr_ptr=3 with req=1001 -> grant 3, then 0. Repeat test 1 at LAT=1 and LAT=7 -> rsp_vld appears at cycles 2 and 8 respectively.
